led_blink_tx: RTL and testbench

Output-side counterpart to the debounced switch input path: accepts a 4-bit value over a valid/ready handshake and presents it to the user as that many timed blinks on one LED, followed by a dark inter-message gap. It sits between event-producing logic (press counters, status codes) and an LED pin on the Go Board, so values can be read by eye without a 7-segment display.

---
 rtl/go_board_pkg.sv | 16 +
 rtl/cycle_timer.sv | 37 +++
 rtl/led_blink_tx.sv | 126 ++++++++++++
 tb/tb_led_blink_tx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/go_board_pkg.sv
// rtl/go_board_pkg.sv - Go Board clock constants and ms-to-cycle conversion
package go_board_pkg;

  localparam int unsigned CLK_HZ        = 25_000_000;
  localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

  // Default blink timing for eye-readable LED messages.
  localparam int unsigned BLINK_ON_MS  = 100;
  localparam int unsigned BLINK_OFF_MS = 100;
  localparam int unsigned BLINK_GAP_MS = 500;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return ms * CYCLES_PER_MS;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - reloadable down-counter flagging the last cycle of a segment
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Val,
  output logic         o_Expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load value is (duration - 1), so expiry marks the final cycle of the segment.
  assign o_Expired = (cnt_q == '0);

  // Reload on strobe, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Load) begin
      cnt_d = i_Load_Val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_tx.sv
// rtl/led_blink_tx.sv - shows a 4-bit value as timed LED blinks followed by a dark gap
module led_blink_tx
  import go_board_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = ms_to_cycles(BLINK_ON_MS),
  parameter int unsigned OFF_CYCLES = ms_to_cycles(BLINK_OFF_MS),
  parameter int unsigned GAP_CYCLES = ms_to_cycles(BLINK_GAP_MS)
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Count,
  input  logic       i_Valid,
  output logic       o_Ready,
  output logic       o_LED,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int unsigned MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_ON_OFF > GAP_CYCLES) ? MAX_ON_OFF : GAP_CYCLES;
  localparam int unsigned TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    rem_q, rem_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_load_val;
  logic          tmr_expired;

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Load     (tmr_load),
    .i_Load_Val (tmr_load_val),
    .o_Expired  (tmr_expired)
  );

  assign o_Ready = (state_q == S_IDLE);
  assign o_LED   = led_q;
  assign o_Busy  = busy_q;
  assign o_Done  = done_q;

  // Message sequencer: every segment change reloads the shared timer in the same cycle.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_Valid) begin
          rem_d    = i_Count;
          tmr_load = 1'b1;
          if (i_Count != 4'd0) begin
            state_d      = S_ON;
            tmr_load_val = ON_LOAD;
          end else begin
            state_d      = S_GAP;
            tmr_load_val = GAP_LOAD;
          end
        end
      end
      S_ON: begin
        if (tmr_expired) begin
          rem_d    = rem_q - 4'd1;
          tmr_load = 1'b1;
          if (rem_q == 4'd1) begin
            state_d      = S_GAP;
            tmr_load_val = GAP_LOAD;
          end else begin
            state_d      = S_OFF;
            tmr_load_val = OFF_LOAD;
          end
        end
      end
      S_OFF: begin
        if (tmr_expired) begin
          state_d      = S_ON;
          tmr_load     = 1'b1;
          tmr_load_val = ON_LOAD;
        end
      end
      S_GAP: begin
        if (tmr_expired) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    led_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  // State, blink count and registered outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      rem_q   <= 4'd0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_led_blink_tx.sv
// tb/tb_led_blink_tx.sv - scoreboard bench for led_blink_tx
module tb_led_blink_tx;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int GAP = 5;

  logic       clk;
  logic       rst_n;
  logic [3:0] i_Count;
  logic       i_Valid;
  logic       o_Ready;
  logic       o_LED;
  logic       o_Busy;
  logic       o_Done;

  int         n_checks;
  int         n_pass;
  bit         pend_done;
  logic [3:0] sb[$];

  led_blink_tx #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .GAP_CYCLES (GAP)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .i_Count (i_Count),
    .i_Valid (i_Valid),
    .o_Ready (o_Ready),
    .o_LED   (o_LED),
    .o_Busy  (o_Busy),
    .o_Done  (o_Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected {led, busy, done, ready} for the current cycle.
  task automatic push(input logic led, input logic busy, input logic done, input logic rdy);
    sb.push_back({led, busy, done, rdy});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [3:0] e;
      e = sb.pop_front();
      chk("out{led,busy,done,rdy}", {28'b0, o_LED, o_Busy, o_Done, o_Ready}, {28'b0, e});
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      push(1'b0, 1'b0, pend_done, 1'b1);
      pend_done = 1'b0;
      i_Valid   = 1'b0;
      step();
    end
  endtask

  // Offer n in the current idle cycle, then expect the full message timeline.
  task automatic run_msg(input int n, input bit hold_valid, input int chg_at,
                         input logic [3:0] chg_val, input int abort_at);
    int total;
    int blinks;
    push(1'b0, 1'b0, pend_done, 1'b1);
    pend_done = 1'b0;
    i_Valid   = 1'b1;
    i_Count   = 4'(n);
    step();
    blinks = (n == 0) ? 0 : n * ON + (n - 1) * OFF;
    total  = blinks + GAP;
    for (int idx = 0; idx < total; idx++) begin
      if (!hold_valid) i_Valid = 1'b0;
      if (idx == chg_at) i_Count = chg_val;
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_led", {31'b0, o_LED}, 32'd0);
        chk("rst_busy", {31'b0, o_Busy}, 32'd0);
        chk("rst_done", {31'b0, o_Done}, 32'd0);
        chk("rst_ready", {31'b0, o_Ready}, 32'd1);
        i_Valid = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
          push(1'b0, 1'b0, 1'b0, 1'b1);
          step();
        end
        push(1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step();
        return;
      end
      push((idx < blinks) && ((idx % (ON + OFF)) < ON), 1'b1, 1'b0, 1'b0);
      step();
    end
    pend_done = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    pend_done = 1'b0;
    rst_n     = 1'b0;
    i_Valid   = 1'b0;
    i_Count   = 4'd0;
    step();
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
    rst_n = 1'b1;
    idle(20);

    run_msg(1, 1'b0, -1, 4'd0, -1);
    idle(3);
    run_msg(3, 1'b0, -1, 4'd0, -1);
    idle(3);
    run_msg(0, 1'b0, -1, 4'd0, -1);
    idle(3);

    // Valid held; count changes to 5 mid-message, next message starts in the done cycle.
    run_msg(2, 1'b1, 4, 4'd5, -1);
    run_msg(5, 1'b0, -1, 4'd0, -1);
    idle(3);

    // Reset during the second ON of a 4-blink message.
    run_msg(4, 1'b0, -1, 4'd0, 6);
    idle(2);
    run_msg(1, 1'b0, -1, 4'd0, -1);
    idle(3);

    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
